// File: rtl/adc_pkg.sv
// Shared types and frame constants for the MCP3008-class ADC reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CS_SETUP = 2'd1,
      SHIFT    = 2'd2,
      CS_HOLD  = 2'd3
   } state_t;

   localparam int FRAME_EDGES     = 17;   // SCLK periods per conversion frame
   localparam int FIRST_DATA_EDGE = 8;    // rising edge that carries B9
   localparam int CMD_BITS        = 5;    // start, SGL, D2, D1, D0
   localparam int ACCEL_MAX       = 1000;

endpackage

// File: rtl/adc_accel_map.sv
// Clamp/scale of a raw 10-bit ADC code into the 0..1000 accel range.
// Latency: combinational; the parent registers y when a frame completes.
// Backpressure: none.
//   x : raw ADC code
//   y : 0 at/below LOW_TH, 1000 at/above HIGH_TH, else (x-LOW_TH)*2
import adc_pkg::*;

module adc_accel_map #(
   parameter int LOW_TH  = 280,
   parameter int HIGH_TH = 780
) (
   input  logic [9:0] x,
   output logic [9:0] y
);

   logic [10:0] x11;
   logic [10:0] scaled;

   always_comb begin
      x11    = {1'b0, x};
      scaled = (x11 - 11'(LOW_TH)) << 1;
      if (x11 <= 11'(LOW_TH)) begin
         y = '0;
      end else if (x11 >= 11'(HIGH_TH)) begin
         y = 10'(ACCEL_MAX);
      end else if (scaled > 11'(ACCEL_MAX)) begin
         // Only reachable if the thresholds span more than 500 codes.
         y = 10'(ACCEL_MAX);
      end else begin
         y = scaled[9:0];
      end
   end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI mode-0 master reading one MCP3008 channel; outputs raw sample and scaled accel.
// Latency: sample_valid 1+34*CLK_DIV cycles after start is accepted; busy drops CS_HIGH_CYC later.
// Backpressure: none; start is only sampled in IDLE, starts while busy are dropped.
//   clk, rst          : clock, synchronous active-high reset
//   start / busy      : conversion request / frame in progress
//   cs_n, sclk, din   : registered SPI outputs; dout : ADC serial data
//   sample, accel     : last raw code and its scaled value, updated with sample_valid
import adc_pkg::*;

module adc_spi_reader #(
   parameter int CLK_DIV     = 27,
   parameter int CHANNEL     = 4,
   parameter int CS_HIGH_CYC = 27,
   parameter int LOW_TH      = 280,
   parameter int HIGH_TH     = 780
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       cs_n,
   output logic       sclk,
   output logic       din,
   input  logic       dout,
   output logic [9:0] sample,
   output logic [9:0] accel,
   output logic       sample_valid
);

   localparam int CNT_MAX = (CLK_DIV > CS_HIGH_CYC) ? CLK_DIV : CS_HIGH_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CMD_BITS-1:0] CMD = {2'b11, 3'(CHANNEL)};

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [4:0]       edge_r, edge_nx;
   logic [9:0]       shreg, shreg_nx;
   logic             cs_n_nx, sclk_nx, din_nx, busy_nx, valid_nx;
   logic [9:0]       sample_nx, accel_nx;
   logic [9:0]       accel_map_y;
   logic             div_done, hold_done;
   logic [2:0]       cmd_idx;

   adc_accel_map #(
      .LOW_TH  (LOW_TH),
      .HIGH_TH (HIGH_TH)
   ) u_map (
      .x (shreg),
      .y (accel_map_y)
   );

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      edge_nx   = edge_r;
      shreg_nx  = shreg;
      cs_n_nx   = cs_n;
      sclk_nx   = sclk;
      din_nx    = din;
      sample_nx = sample;
      accel_nx  = accel;
      valid_nx  = 1'b0;
      div_done  = (cnt == CNT_W'(CLK_DIV - 1));
      hold_done = (cnt == CNT_W'(CS_HIGH_CYC - 1));
      // Falling edge r presents command bit r+1 (MSB-first numbering from 1).
      cmd_idx   = 3'(CMD_BITS - 1) - edge_r[2:0];

      case (state)
         IDLE: begin
            if (start) begin
               state_nx = CS_SETUP;
               cs_n_nx  = 1'b0;
               sclk_nx  = 1'b0;
               din_nx   = CMD[CMD_BITS-1];
               cnt_nx   = '0;
            end
         end
         CS_SETUP: begin
            if (div_done) begin
               cnt_nx   = '0;
               sclk_nx  = 1'b1;
               edge_nx  = 5'd1;
               state_nx = SHIFT;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         SHIFT: begin
            if (!div_done) begin
               cnt_nx = cnt + 1'b1;
            end else begin
               cnt_nx = '0;
               if (sclk) begin
                  // Falling edge edge_r.
                  sclk_nx = 1'b0;
                  if (edge_r == 5'(FRAME_EDGES)) begin
                     cs_n_nx   = 1'b1;
                     din_nx    = 1'b0;
                     valid_nx  = 1'b1;
                     sample_nx = shreg;
                     accel_nx  = accel_map_y;
                     edge_nx   = '0;
                     state_nx  = CS_HOLD;
                  end else if (edge_r < 5'(CMD_BITS)) begin
                     din_nx = CMD[cmd_idx];
                  end else begin
                     din_nx = 1'b0;
                  end
               end else begin
                  // Rising edge edge_r+1; data bits arrive B9 first.
                  sclk_nx = 1'b1;
                  edge_nx = edge_r + 5'd1;
                  if (edge_r >= 5'(FIRST_DATA_EDGE - 1)) begin
                     shreg_nx = {shreg[8:0], dout};
                  end
               end
            end
         end
         CS_HOLD: begin
            if (hold_done) begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase

      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         edge_r       <= '0;
         shreg        <= '0;
         cs_n         <= 1'b1;
         sclk         <= 1'b0;
         din          <= 1'b0;
         busy         <= 1'b0;
         sample_valid <= 1'b0;
         sample       <= '0;
         accel        <= '0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         edge_r       <= edge_nx;
         shreg        <= shreg_nx;
         cs_n         <= cs_n_nx;
         sclk         <= sclk_nx;
         din          <= din_nx;
         busy         <= busy_nx;
         sample_valid <= valid_nx;
         sample       <= sample_nx;
         accel        <= accel_nx;
      end
   end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Testbench for adc_spi_reader: two instances (CHANNEL 4 and 7) driven by ADC models.
// Latency: n/a.
// Backpressure: n/a.
module tb_adc_spi_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] start, busy, cs_n, sclk, din, sv;
   logic       dout0, dout1;
   logic [9:0] sample0, sample1, accel0, accel1;
   logic [9:0] code [2];
   int         fall0, fall1;
   int         errors = 0;
   int         checks = 0;
   int         t = 0;

   adc_spi_reader #(.CLK_DIV(2), .CHANNEL(4), .CS_HIGH_CYC(4), .LOW_TH(280), .HIGH_TH(780)) dut (
      .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .cs_n(cs_n[0]), .sclk(sclk[0]),
      .din(din[0]), .dout(dout0), .sample(sample0), .accel(accel0), .sample_valid(sv[0]));

   adc_spi_reader #(.CLK_DIV(2), .CHANNEL(7), .CS_HIGH_CYC(4), .LOW_TH(280), .HIGH_TH(780)) dut7 (
      .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .cs_n(cs_n[1]), .sclk(sclk[1]),
      .din(din[1]), .dout(dout1), .sample(sample1), .accel(accel1), .sample_valid(sv[1]));

   // ADC model: after falling edge k it drives B(16-k) for k = 7..16.
   function automatic logic adc_bit(input logic [9:0] c, input int f);
      logic [9:0] tmp;
      if (f < 7 || f > 16) return 1'b0;
      tmp = c >> (16 - f);
      return tmp[0];
   endfunction

   always @(negedge cs_n[0]) begin fall0 = 0; dout0 = 1'b0; end
   always @(negedge sclk[0]) begin fall0 = fall0 + 1; dout0 = adc_bit(code[0], fall0); end
   always @(negedge cs_n[1]) begin fall1 = 0; dout1 = 1'b0; end
   always @(negedge sclk[1]) begin fall1 = fall1 + 1; dout1 = adc_bit(code[1], fall1); end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      t++;
   endtask

   function automatic logic [9:0] smp(input int i);
      return (i == 0) ? sample0 : sample1;
   endfunction

   function automatic logic [9:0] acc(input int i);
      return (i == 0) ? accel0 : accel1;
   endfunction

   // Start pulse at cycle 0; observe until busy drops.
   task automatic frame(input int i, input logic [9:0] c, output int tv, output int tb,
                        output int rises, output logic [4:0] cmd,
                        output logic [9:0] s, output logic [9:0] a);
      logic prev;
      code[i] = c;
      tv = -1; tb = -1; rises = 0; cmd = '0; s = '0; a = '0;
      t = 0;
      start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
      chk("cs_n_low_cycle1", int'(cs_n[i]), 0);
      prev = sclk[i];
      for (int k = 0; k < 200 && tb < 0; k++) begin
         if (sclk[i] && !prev) begin
            if (rises < 5) cmd = {cmd[3:0], din[i]};
            rises++;
         end
         prev = sclk[i];
         if (sv[i]) begin tv = t; s = smp(i); a = acc(i); end
         if (!busy[i]) tb = t;
         if (tb < 0) tick();
      end
   endtask

   typedef struct {
      int         inst;
      logic [9:0] code;
      int         exp_sample;
      int         exp_accel;
      logic [4:0] exp_cmd;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int         tv, tb, rises, nsv, nrun, hi, r, svc, relow;
      logic [4:0] cmd;
      logic [9:0] s, a;
      logic       prev, seen_low, seen_sv;
      int         svt [3];
      int         runs [2];
      int         rcnt [3];

      vecs[0] = '{0, 10'd512,  512,  464, 5'b11100};
      vecs[1] = '{0, 10'd0,    0,    0,   5'b11100};
      vecs[2] = '{0, 10'd280,  280,  0,   5'b11100};
      vecs[3] = '{0, 10'd281,  281,  2,   5'b11100};
      vecs[4] = '{0, 10'd779,  779,  998, 5'b11100};
      vecs[5] = '{0, 10'd780,  780,  1000, 5'b11100};
      vecs[6] = '{0, 10'd1023, 1023, 1000, 5'b11100};
      vecs[7] = '{1, 10'h2AA,  682,  804, 5'b11111};

      rst = 1'b1; start = '0; code[0] = '0; code[1] = '0;
      dout0 = 1'b0; dout1 = 1'b0; fall0 = 0; fall1 = 0;
      tick(); tick(); tick();
      chk("rst_cs_n", int'(cs_n[0]), 1);
      chk("rst_sclk", int'(sclk[0]), 0);
      chk("rst_din", int'(din[0]), 0);
      chk("rst_busy", int'(busy[0]), 0);
      chk("rst_valid", int'(sv[0]), 0);
      chk("rst_sample", int'(sample0), 0);
      chk("rst_accel", int'(accel0), 0);
      rst = 1'b0;
      tick();

      // Table-driven frames: mapping, clamp boundaries, timing, command bits.
      for (int v = 0; v < 8; v++) begin
         frame(vecs[v].inst, vecs[v].code, tv, tb, rises, cmd, s, a);
         chk($sformatf("v%0d_sample", v), int'(s), vecs[v].exp_sample);
         chk($sformatf("v%0d_accel", v), int'(a), vecs[v].exp_accel);
         chk($sformatf("v%0d_cmd", v), int'(cmd), int'(vecs[v].exp_cmd));
         chk($sformatf("v%0d_valid_cycle", v), tv, 69);
         chk($sformatf("v%0d_busy_low_cycle", v), tb, 73);
         chk($sformatf("v%0d_sclk_rises", v), rises, 17);
      end

      // start held high: three back-to-back frames.
      code[0] = 10'd300;
      nsv = 0; nrun = 0; hi = 0; r = 0; seen_low = 1'b0;
      for (int k = 0; k < 3; k++) begin svt[k] = 0; rcnt[k] = 0; end
      runs[0] = 0; runs[1] = 0;
      t = 0;
      start[0] = 1'b1;
      prev = sclk[0];
      for (int k = 0; k < 300 && nsv < 3; k++) begin
         tick();
         if (sclk[0] && !prev) r++;
         prev = sclk[0];
         if (cs_n[0]) hi++;
         else begin
            if (seen_low && hi > 0 && nrun < 2) begin runs[nrun] = hi; nrun++; end
            hi = 0;
            seen_low = 1'b1;
         end
         if (sv[0]) begin svt[nsv] = t; rcnt[nsv] = r; r = 0; nsv++; end
      end
      start[0] = 1'b0;
      chk("b2b_valid_count", nsv, 3);
      chk("b2b_valid0", svt[0], 69);
      chk("b2b_valid1", svt[1], 142);
      chk("b2b_valid2", svt[2], 215);
      chk("b2b_cs_high0", runs[0], 5);
      chk("b2b_cs_high1", runs[1], 5);
      chk("b2b_rises0", rcnt[0], 17);
      chk("b2b_rises1", rcnt[1], 17);
      chk("b2b_rises2", rcnt[2], 17);
      chk("b2b_accel", int'(accel0), 40);
      for (int k = 0; k < 20 && busy[0]; k++) tick();
      chk("b2b_idle", int'(busy[0]), 0);
      tick();

      // start pulses mid-frame are ignored, not queued.
      code[0] = 10'd700;
      svc = 0; tv = -1; relow = 0; seen_sv = 1'b0;
      t = 0;
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      for (int k = 0; k < 150; k++) begin
         if (t == 19 || t == 39) start[0] = 1'b1;
         if (t == 20 || t == 40) start[0] = 1'b0;
         if (sv[0]) begin svc++; tv = t; seen_sv = 1'b1; end
         if (seen_sv && !cs_n[0]) relow++;
         tick();
      end
      chk("ign_valid_count", svc, 1);
      chk("ign_valid_cycle", tv, 69);
      chk("ign_no_new_frame", relow, 0);
      chk("ign_accel", int'(accel0), 840);

      // Reset mid-frame with a prior sample of 512.
      frame(0, 10'd512, tv, tb, rises, cmd, s, a);
      chk("pre_rst_sample", int'(sample0), 512);
      t = 0;
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      while (t < 30) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_cs_n", int'(cs_n[0]), 1);
      chk("mid_rst_sclk", int'(sclk[0]), 0);
      chk("mid_rst_din", int'(din[0]), 0);
      chk("mid_rst_busy", int'(busy[0]), 0);
      chk("mid_rst_sample", int'(sample0), 0);
      chk("mid_rst_accel", int'(accel0), 0);
      svc = 0;
      for (int k = 0; k < 100; k++) begin
         if (sv[0]) svc++;
         tick();
      end
      chk("mid_rst_no_valid", svc, 0);
      frame(0, 10'd512, tv, tb, rises, cmd, s, a);
      chk("post_rst_sample", int'(s), 512);
      chk("post_rst_accel", int'(a), 464);
      chk("post_rst_valid_cycle", tv, 69);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
